// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the programmable-threshold synchronous FIFO.
// Read-mode encodings and the occupancy-counter width function live here.
package sync_fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Counter must represent 0..DEPTH inclusive, hence one bit beyond the address width.
  function automatic int clog2p1(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// DEPTH x WIDTH storage array: one synchronous write port, one asynchronous read port.
// Contents are deliberately left unreset.
module fifo_mem_dp #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with live-programmable almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and an optional first-word-fall-through read mode.
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int FWFT  = FIFO_MODE_STD,
  parameter int CW    = clog2p1(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             write,
  input  logic             read,
  input  logic [WIDTH-1:0] data_in,
  input  logic [CW-1:0]    af_thresh,
  input  logic [CW-1:0]    ae_thresh,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow,
  output logic [CW-1:0]    cnt
);

  localparam int AW = CW - 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_prog: DEPTH must be a power of 2 and at least 2");
  end
  if ((FWFT != FIFO_MODE_STD) && (FWFT != FIFO_MODE_FWFT)) begin : g_bad_fwft
    $error("sync_fifo_prog: FWFT must be 0 or 1");
  end
  if (CW != clog2p1(DEPTH)) begin : g_bad_cw
    $error("sync_fifo_prog: CW is derived from DEPTH and must not be overridden");
  end

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             empty_w, full_w;
  logic             rd_ok, wr_ok;
  logic             mem_we;
  logic [WIDTH-1:0] mem_rdata;

  assign empty_w = (cnt_q == '0);
  assign full_w  = (cnt_q == DEPTH_C);

  // A write into a full FIFO is still accepted when a read frees the slot in the same cycle.
  assign rd_ok = read && !empty_w;
  assign wr_ok = write && (!full_w || rd_ok);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    data_out_d  = data_out_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    mem_we      = 1'b0;

    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      cnt_d       = '0;
      data_out_d  = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_ok) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        if (FWFT == FIFO_MODE_STD) begin
          data_out_d = mem_rdata;
        end
      end
      case ({wr_ok, rd_ok})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
      if (write && !wr_ok) begin
        overflow_d = 1'b1;
      end
      if (read && !rd_ok) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      data_out_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      data_out_q  <= data_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem_dp #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  // In FWFT mode the head word is shown directly; an empty FIFO presents zero.
  assign data_out = (FWFT == FIFO_MODE_FWFT) ? (empty_w ? '0 : mem_rdata) : data_out_q;

  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (cnt_q >= af_thresh);
  assign almost_empty = (cnt_q <= ae_thresh);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign cnt          = cnt_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: a registered-read instance and an FWFT instance
// share stimulus; read data is checked against a scoreboard queue.
module tb_sync_fifo_prog;

  localparam int DEPTH = 8;
  localparam int WIDTH = 32;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             clear = 1'b0;
  logic             write = 1'b0;
  logic             read = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [CW-1:0]    af_thresh = 4'd8;
  logic [CW-1:0]    ae_thresh = 4'd0;

  logic [WIDTH-1:0] data_out0, data_out1;
  logic             full0, empty0, almost_full0, almost_empty0, overflow0, underflow0;
  logic             full1, empty1, almost_full1, almost_empty1, overflow1, underflow1;
  logic [CW-1:0]    cnt0, cnt1;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  sync_fifo_prog #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(0)) u_std (
    .clk(clk), .reset_n(reset_n), .clear(clear), .write(write), .read(read),
    .data_in(data_in), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .data_out(data_out0), .full(full0), .empty(empty0), .almost_full(almost_full0),
    .almost_empty(almost_empty0), .overflow(overflow0), .underflow(underflow0), .cnt(cnt0)
  );

  sync_fifo_prog #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(1)) u_fwft (
    .clk(clk), .reset_n(reset_n), .clear(clear), .write(write), .read(read),
    .data_in(data_in), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .data_out(data_out1), .full(full1), .empty(empty1), .almost_full(almost_full1),
    .almost_empty(almost_empty1), .overflow(overflow1), .underflow(underflow1), .cnt(cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock with the given controls; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic w, input logic r, input logic c, input logic [31:0] d);
    write = w; read = r; clear = c; data_in = d;
    @(posedge clk);
    #1;
    write = 1'b0; read = 1'b0; clear = 1'b0;
    $display("t=%0t w=%0b r=%0b clr=%0b din=%h | std dout=%h cnt=%0d | fwft dout=%h cnt=%0d",
             $time, w, r, c, d, data_out0, cnt0, data_out1, cnt1);
  endtask

  task automatic wr(input logic [31:0] d);
    sb.push_back(d);
    cyc(1'b1, 1'b0, 1'b0, d);
  endtask

  task automatic rd_std(input string tag);
    logic [31:0] exp;
    exp = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk(tag, data_out0, exp);
  endtask

  task automatic do_clear();
    cyc(1'b0, 1'b0, 1'b1, '0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic w, r, rok, wok;
    logic [31:0] d;
    int n_wr;
    int guard;

    // Reset state
    #3;
    chk("rst_cnt", cnt0, 0);
    chk("rst_empty", empty0, 1);
    chk("rst_full", full0, 0);
    chk("rst_dout", data_out0, 0);
    chk("rst_ovf", overflow0, 0);
    chk("rst_udf", underflow0, 0);
    chk("rst_fwft_dout", data_out1, 0);
    chk("rst_fwft_empty", empty1, 1);
    #9 reset_n = 1'b1;

    // Async reset mid-burst
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk("udf_on_empty_read", underflow0, 1);
    wr(32'hA1); wr(32'hA2); wr(32'hA3); wr(32'hA4);
    rd_std("pre_reset_read");
    chk("pre_reset_cnt", cnt0, 3);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_cnt", cnt0, 0);
    chk("async_rst_empty", empty0, 1);
    chk("async_rst_dout", data_out0, 0);
    chk("async_rst_udf", underflow0, 0);
    chk("async_rst_ovf", overflow0, 0);
    #1 reset_n = 1'b1;
    sb.delete();

    // Synchronous clear overrides a simultaneous write
    wr(32'hB1); wr(32'hB2);
    rd_std("pre_clear_read");
    cyc(1'b1, 1'b0, 1'b1, 32'hC0);
    chk("clear_cnt", cnt0, 0);
    chk("clear_empty", empty0, 1);
    chk("clear_dout", data_out0, 0);
    sb.delete();
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk("clear_nothing_stored_udf", underflow0, 1);
    chk("clear_nothing_stored_cnt", cnt0, 0);
    chk("rejected_read_holds_dout", data_out0, 0);
    do_clear();
    chk("clear_udf", underflow0, 0);

    // Fill, partial drain, wrap, full drain
    for (int i = 0; i < 8; i++) wr(32'h10 + i);
    chk("fill_full", full0, 1);
    chk("fill_cnt", cnt0, 8);
    for (int i = 0; i < 4; i++) rd_std("wrap_read_a");
    for (int i = 0; i < 4; i++) wr(32'h20 + i);
    chk("wrap_full", full0, 1);
    for (int i = 0; i < 8; i++) rd_std("wrap_read_b");
    chk("drain_empty", empty0, 1);
    chk("drain_cnt", cnt0, 0);

    // Simultaneous read+write when full, then overflow
    for (int i = 0; i < 8; i++) wr(32'h30 + i);
    d = sb.pop_front();
    sb.push_back(32'hAA);
    cyc(1'b1, 1'b1, 1'b0, 32'hAA);
    chk("full_rw_dout", data_out0, d);
    chk("full_rw_cnt", cnt0, 8);
    chk("full_rw_ovf", overflow0, 0);
    cyc(1'b1, 1'b0, 1'b0, 32'hBB);
    chk("ovf_set", overflow0, 1);
    chk("ovf_cnt", cnt0, 8);
    cyc(1'b0, 1'b0, 1'b0, '0);
    chk("ovf_sticky", overflow0, 1);
    for (int i = 0; i < 8; i++) rd_std("post_ovf_read");
    chk("post_ovf_empty", empty0, 1);
    chk("ovf_sticky_drain", overflow0, 1);
    do_clear();
    chk("ovf_cleared", overflow0, 0);

    // Empty with read+write; one entry with read+write
    wr(32'h77);
    rd_std("set_dout_77");
    sb.push_back(32'h55);
    cyc(1'b1, 1'b1, 1'b0, 32'h55);
    chk("empty_rw_cnt", cnt0, 1);
    chk("empty_rw_udf", underflow0, 1);
    chk("empty_rw_dout_hold", data_out0, 32'h77);
    rd_std("empty_rw_read55");
    wr(32'h61);
    d = sb.pop_front();
    sb.push_back(32'h62);
    cyc(1'b1, 1'b1, 1'b0, 32'h62);
    chk("one_rw_dout", data_out0, d);
    chk("one_rw_cnt", cnt0, 1);
    rd_std("one_rw_read62");
    do_clear();

    // Thresholds
    af_thresh = 4'd6; ae_thresh = 4'd2;
    #1;
    chk("thr_ae_0", almost_empty0, 1);
    chk("thr_af_0", almost_full0, 0);
    for (int k = 1; k <= 7; k++) begin
      wr(32'h40 + k);
      chk("thr_cnt", cnt0, k);
      chk("thr_ae", almost_empty0, (k <= 2));
      chk("thr_af", almost_full0, (k >= 6));
    end
    af_thresh = 4'd8;
    #1;
    chk("thr_af_live_8", almost_full0, 0);
    af_thresh = 4'd0; ae_thresh = 4'd8;
    #1;
    chk("thr_af_zero", almost_full0, 1);
    chk("thr_ae_depth", almost_empty0, 1);
    af_thresh = 4'd8; ae_thresh = 4'd0;
    do_clear();

    // FWFT instance
    cyc(1'b1, 1'b0, 1'b0, 32'h3C);
    chk("fwft_head_visible", data_out1, 32'h3C);
    chk("fwft_cnt1", cnt1, 1);
    chk("fwft_not_full", full1, 0);
    cyc(1'b0, 1'b0, 1'b0, '0);
    chk("fwft_head_stable", data_out1, 32'h3C);
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk("fwft_pop_empty", empty1, 1);
    chk("fwft_pop_dout0", data_out1, 0);
    chk("fwft_no_udf", underflow1, 0);
    chk("fwft_no_ovf", overflow1, 0);
    chk("fwft_ae", almost_empty1, 1);
    chk("fwft_af", almost_full1, 0);

    n_wr = 0;
    guard = 0;
    while (n_wr < 100 && guard < 1000) begin
      w = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      d = $urandom;
      if (sb.size() != 0) chk("fwft_stream_head", data_out1, sb[0]);
      else                chk("fwft_stream_empty", data_out1, 0);
      rok = r && (sb.size() != 0);
      wok = w && ((sb.size() < DEPTH) || rok);
      if (rok) void'(sb.pop_front());
      if (wok) begin
        sb.push_back(d);
        n_wr++;
      end
      cyc(w, r, 1'b0, d);
      chk("fwft_stream_cnt", cnt1, sb.size());
      guard++;
    end
    chk("fwft_stream_words", n_wr, 100);
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      chk("fwft_drain_head", data_out1, sb.pop_front());
      cyc(1'b0, 1'b1, 1'b0, '0);
      guard++;
    end
    chk("fwft_drain_left", sb.size(), 0);
    chk("fwft_final_empty", empty1, 1);
    chk("fwft_final_dout", data_out1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
